digit_field_ctrl: RTL and testbench
===================================

Name: digit_field_ctrl

Overview:
Controller for the 7-segment digit datapath (digit decoder followed by segment-to-bitmap stage). It owns a small register file of BCD digits and shares write access between two requesters using a round-robin arbiter. Requesters either write one digit or issue a BCD increment, which a multi-cycle FSM ripples through the digits. During the video scan it maps hpos/vpos to the digit, line and column for the current pixel and feeds them, registered, to the decoder and bitmap stages.

Parameters:
NDIGITS, 4, number of digit cells, legal range 1..8; digit 0 is least significant and drawn rightmost.
X0, 0, left pixel column of the digit field.
Y0, 0, top pixel row of the digit field.

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
hpos  input  9  horizontal scan position from the sync generator
vpos  input  9  vertical scan position from the sync generator
display_on  input  1  active-video flag from the sync generator
req  input  2  request per requester, bit r belongs to requester r
cmd_inc  input  2  per requester: 1 = BCD increment starting at addr, 0 = write data
wr_addr  input  6  {addr1[2:0], addr0[2:0]}, digit index
wr_data  input  8  {data1[3:0], data0[3:0]}
gnt  output  2  one-cycle completion pulse, bit r for requester r
busy  output  1  FSM not in IDLE
digit  output  4  digit value to the decoder; 4'hF when blank
yofs  output  3  line within the cell to the bitmap stage
xofs  output  3  column within the cell
in_field  output  1  current pixel lies inside the digit field
overflow  output  1  one-cycle pulse when an increment carries out of digit NDIGITS-1

Behaviour:
- Reset values:
  - Outputs: digit=4'hF, xofs=0, yofs=0, in_field=0, gnt=0, busy=0, overflow=0.
  - Internal: all digit registers=0; FSM in IDLE; round-robin pointer set so requester 0 wins first.
- Reset asserted mid-operation: the operation is dropped, digits are cleared to 0, and no gnt is issued.
- Scan geometry:
  - relx=hpos-X0, rely=vpos-Y0, each 9 bit.
  - in_field = display_on && relx<16*NDIGITS && rely<16 (compare unsigned, so hpos<X0 wraps to a large value and falls outside).
  - Cell c=relx[6:4] selects digit index NDIGITS-1-c; xofs=relx[3:1]; yofs=rely[3:1]. Each cell is 16x16 pixels (5x5 glyph at 2x scale).
- Scan latency and blanking:
  - All scan outputs are registered, giving exactly 1 cycle latency from hpos/vpos.
  - When in_field=0: digit=4'hF; xofs/yofs still follow the formula.
- Arbitration:
  - A request is accepted only when FSM=IDLE and display_on=0.
  - If both requesters are asserted, the one not granted last wins. The pointer updates on acceptance.
  - On acceptance the FSM latches the requester id, cmd, addr and data.
  - A requester must hold req until its gnt; dropping req before acceptance withdraws it.
  - Once accepted, an operation runs to completion regardless of display_on.
- FSM states IDLE, WRITE, INC, DONE:
  - IDLE -> WRITE or INC on acceptance.
  - WRITE: one cycle. Stores data to digit[addr]; values 10..15 are stored as-is and the decoder blanks them. -> DONE.
  - INC, starting at index i=addr, one update per cycle:
    - If digit[i]>=9: set digit[i]=0 and carry. If i==NDIGITS-1, pulse overflow and go to DONE; otherwise i=i+1 and stay in INC.
    - Otherwise: digit[i]=digit[i]+1 -> DONE.
  - DONE: gnt[id]=1 for this cycle -> IDLE.
  - An addr >= NDIGITS skips WRITE/INC and goes straight to DONE with no change; gnt is still issued.
- Update timing: the latency from acceptance edge to gnt cycle is 1 + number of update cycles. A digit update becomes visible on the digit output at the next output-register edge.
- A requester still holding req during DONE is not re-accepted in that cycle; it competes again from IDLE.

Optional Feature:
DIGIT_LEADING_BLANK_EN
- Defined: digit outputs 4'hF for every index above the highest nonzero digit. Digit 0 is never blanked, so 0042 shows as "  42".
- Not defined: all digits are shown, including leading zeros.

Test Plan:
- Reset, NDIGITS=4, X0=0, Y0=0, display_on=1: digit=0 during hpos 0..63 / vpos 0..15 (1 cycle delay); hpos=64 -> in_field=0, digit=F.
- display_on=0, req[0], cmd_inc=0, addr0=2, data0=7 -> WRITE, then gnt[0] high one cycle, 2 cycles after acceptance; later a scan at hpos=16 shows digit=7.
- Digits 0999, inc at addr 0 -> 4 update cycles, result 1000, gnt after 5 cycles, overflow=0. Digits 9999, inc -> 0000, overflow pulses once.
- req=2'b11 held from reset during blanking -> gnt[0] first, then gnt[1], then alternation; no requester is starved.
- req[1] raised while display_on=1 -> no acceptance and busy=0 until display_on falls.
- Reset asserted during INC of 9999 -> next cycle busy=0, all digits 0, no gnt, no overflow pulse.

Source files
------------

// File: rtl/digit_field_ctrl.sv
// digit_field_ctrl: BCD digit register file with a two-requester round-robin
// write/increment port, plus scan-position mapping for a 7-segment digit field.
// Optional build macro: DIGIT_LEADING_BLANK_EN blanks zero digits above the
// highest nonzero digit (digit 0 is always shown).
module digit_field_ctrl #(
    parameter int unsigned NDIGITS = 4,
    parameter logic [8:0]  X0      = 9'd0,
    parameter logic [8:0]  Y0      = 9'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic [1:0] req,
    input  logic [1:0] cmd_inc,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [3:0] digit,
    output logic [2:0] yofs,
    output logic [2:0] xofs,
    output logic       in_field,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, WRITE, INC, DONE} state_t;

    localparam logic [8:0] FIELD_W = 9'(16 * NDIGITS);
    localparam logic [2:0] TOP_IDX = 3'(NDIGITS - 1);

    state_t             state_q, state_d;
    logic [3:0]         digits_q [NDIGITS];
    logic [3:0]         digits_d [NDIGITS];
    logic               id_q, id_d;
    logic [2:0]         idx_q, idx_d;
    logic [3:0]         data_q, data_d;
    logic               last_q, last_d;
    logic               overflow_q, overflow_d;
    logic [3:0]         digit_q, digit_d;
    logic [2:0]         xofs_q, xofs_d;
    logic [2:0]         yofs_q, yofs_d;
    logic               in_field_q, in_field_d;

    logic               win;
    logic [2:0]         win_addr;
    logic [3:0]         win_data;
    logic [3:0]         cur_digit;
    logic               upd_en;
    logic [3:0]         upd_val;
    logic [8:0]         relx, rely;
    logic [2:0]         sidx;
    logic [3:0]         sval;
    logic [NDIGITS-1:0] lead_blank;
`ifdef DIGIT_LEADING_BLANK_EN
    logic               upper_zero;
`endif

    // Pick the winning requester; on a tie the one not granted last wins
    always_comb begin
        win      = (req == 2'b11) ? ~last_q : req[1];
        win_addr = win ? wr_addr[5:3] : wr_addr[2:0];
        win_data = win ? wr_data[7:4] : wr_data[3:0];
    end

    // Digit addressed by the in-flight operation
    always_comb begin
        cur_digit = '0;
        for (int unsigned k = 0; k < NDIGITS; k++) begin
            if (idx_q == 3'(k)) cur_digit = digits_q[k];
        end
    end

    // Operation FSM: accept, write or ripple increment, then grant
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        id_d       = id_q;
        idx_d      = idx_q;
        data_d     = data_q;
        last_d     = last_q;
        overflow_d = 1'b0;
        upd_en     = 1'b0;
        upd_val    = '0;
        case (state_q)
            IDLE: begin
                if (!display_on && (req != 2'b00)) begin
                    id_d   = win;
                    last_d = win;
                    idx_d  = win_addr;
                    data_d = win_data;
                    if ({29'd0, win_addr} >= NDIGITS) state_d = DONE;
                    else if (cmd_inc[win])            state_d = INC;
                    else                              state_d = WRITE;
                end
            end
            WRITE: begin
                upd_en  = 1'b1;
                upd_val = data_q;
                state_d = DONE;
            end
            INC: begin
                upd_en = 1'b1;
                if (cur_digit >= 4'd9) begin
                    upd_val = '0;
                    if (idx_q == TOP_IDX) begin
                        overflow_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    upd_val = cur_digit + 4'd1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        for (int unsigned k = 0; k < NDIGITS; k++) begin
            if (upd_en && (idx_q == 3'(k))) digits_d[k] = upd_val;
        end
    end

`ifdef DIGIT_LEADING_BLANK_EN
    // Blank each digit whose own and all higher digits are zero (never digit 0)
    always_comb begin
        lead_blank = '0;
        upper_zero = 1'b1;
        for (int unsigned k = NDIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero && (digits_q[k] == 4'd0);
            lead_blank[k] = upper_zero;
        end
    end
`else
    // All digits shown, leading zeros included
    always_comb begin
        lead_blank = '0;
    end
`endif

    // Map scan position to cell, line and column; blank outside the field
    always_comb begin
        relx       = hpos - X0;
        rely       = vpos - Y0;
        in_field_d = display_on && (relx < FIELD_W) && (rely < 9'd16);
        xofs_d     = relx[3:1];
        yofs_d     = rely[3:1];
        sidx       = TOP_IDX - relx[6:4];
        sval       = 4'hF;
        for (int unsigned k = 0; k < NDIGITS; k++) begin
            if (sidx == 3'(k)) sval = lead_blank[k] ? 4'hF : digits_q[k];
        end
        digit_d = in_field_d ? sval : 4'hF;
    end

    // State, digit file and registered scan outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            for (int unsigned k = 0; k < NDIGITS; k++) digits_q[k] <= '0;
            id_q       <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            last_q     <= 1'b1;
            overflow_q <= 1'b0;
            digit_q    <= 4'hF;
            xofs_q     <= '0;
            yofs_q     <= '0;
            in_field_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            id_q       <= id_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            digit_q    <= digit_d;
            xofs_q     <= xofs_d;
            yofs_q     <= yofs_d;
            in_field_q <= in_field_d;
        end
    end

    // Drive outputs; grant pulses for the owner during DONE
    always_comb begin
        busy = (state_q != IDLE);
        gnt  = '0;
        if (state_q == DONE) gnt[id_q] = 1'b1;
        overflow = overflow_q;
        digit    = digit_q;
        xofs     = xofs_q;
        yofs     = yofs_q;
        in_field = in_field_q;
    end

endmodule

// File: tb/tb_digit_field_ctrl.sv
// Self-checking bench for digit_field_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_digit_field_ctrl;
    localparam int ND = 4;
    localparam int XO = 0;
    localparam int YO = 0;
`ifdef DIGIT_LEADING_BLANK_EN
    localparam bit LEAD_EN = 1'b1;
`else
    localparam bit LEAD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos, vpos;
    logic       display_on;
    logic [1:0] req, cmd_inc;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] gnt;
    logic       busy, in_field, overflow;
    logic [3:0] digit;
    logic [2:0] xofs, yofs;

    int n_tests = 0;
    int n_fail  = 0;

    digit_field_ctrl #(.NDIGITS(ND), .X0(9'(XO)), .Y0(9'(YO))) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .req(req), .cmd_inc(cmd_inc),
        .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt), .busy(busy),
        .digit(digit), .yofs(yofs), .xofs(xofs), .in_field(in_field),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         mdig [ND];
    int         q_idx[$];
    int         q_val[$];
    bit         started = 1'b0;
    bit         m_busy, m_gnt, m_id, m_last, m_ovf_op;
    int         m_w, m_a, m_d, rx, ry, di;
    bit         m_inc, inf;
    logic [3:0] e_digit;
    logic [2:0] e_xofs, e_yofs;
    logic       e_in, e_busy, e_ovf;
    logic [1:0] e_gnt;

    function automatic bit lead_blanked(input int idx);
        if (!LEAD_EN || idx == 0) return 1'b0;
        for (int k = idx; k < ND; k++) if (mdig[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // list of (index, new value) changes an operation will make, one per cycle
    task automatic plan_op(input int a, input int d, input bit inc);
        q_idx.delete();
        q_val.delete();
        m_ovf_op = 1'b0;
        if (a < ND) begin
            if (!inc) begin
                q_idx.push_back(a);
                q_val.push_back(d);
            end else begin
                for (int i = a; i < ND; i++) begin
                    if (mdig[i] >= 9) begin
                        q_idx.push_back(i);
                        q_val.push_back(0);
                        if (i == ND - 1) m_ovf_op = 1'b1;
                    end else begin
                        q_idx.push_back(i);
                        q_val.push_back(mdig[i] + 1);
                        break;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            for (int k = 0; k < ND; k++) mdig[k] = 0;
            q_idx.delete();
            q_val.delete();
            m_busy = 0; m_gnt = 0; m_id = 0; m_last = 1; m_ovf_op = 0;
            e_digit = 4'hF; e_xofs = 0; e_yofs = 0; e_in = 0;
            e_busy = 0; e_gnt = 0; e_ovf = 0;
        end else begin
            rx  = (int'(hpos) - XO + 512) % 512;
            ry  = (int'(vpos) - YO + 512) % 512;
            inf = display_on && (rx < 16 * ND) && (ry < 16);
            e_in   = inf;
            e_xofs = 3'((rx % 16) / 2);
            e_yofs = 3'((ry % 16) / 2);
            if (inf) begin
                di = ND - 1 - rx / 16;
                e_digit = lead_blanked(di) ? 4'hF : 4'(mdig[di]);
            end else begin
                e_digit = 4'hF;
            end
            if (!m_busy) begin
                if (!display_on && req != 2'b00) begin
                    m_w    = (req == 2'b11) ? int'(!m_last) : int'(req[1]);
                    m_last = m_w[0];
                    m_id   = m_w[0];
                    m_a    = (m_w == 1) ? int'(wr_addr[5:3]) : int'(wr_addr[2:0]);
                    m_d    = (m_w == 1) ? int'(wr_data[7:4]) : int'(wr_data[3:0]);
                    m_inc  = cmd_inc[m_w];
                    plan_op(m_a, m_d, m_inc);
                    m_busy = 1;
                    m_gnt  = (q_idx.size() == 0);
                end
            end else if (m_gnt) begin
                m_busy = 0;
                m_gnt  = 0;
            end else begin
                di = q_idx.pop_front();
                mdig[di] = q_val.pop_front();
                if (q_idx.size() == 0) m_gnt = 1;
            end
            e_busy = m_busy;
            e_gnt  = m_gnt ? (m_id ? 2'b10 : 2'b01) : 2'b00;
            e_ovf  = m_gnt && m_ovf_op;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_digit",    32'(digit),    32'(e_digit));
            chk("m_in_field", 32'(in_field), 32'(e_in));
            chk("m_xofs",     32'(xofs),     32'(e_xofs));
            chk("m_yofs",     32'(yofs),     32'(e_yofs));
            chk("m_busy",     32'(busy),     32'(e_busy));
            chk("m_gnt",      32'(gnt),      32'(e_gnt));
            chk("m_overflow", 32'(overflow), 32'(e_ovf));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_op(input int r, input bit inc, input int a, input int d,
                         output int lat, output int ovf_seen);
        display_on = 1'b0;
        req        = 2'b00;
        req[r]     = 1'b1;
        cmd_inc[r] = inc;
        wr_addr[r*3 +: 3] = 3'(a);
        wr_data[r*4 +: 4] = 4'(d);
        lat      = 0;
        ovf_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (overflow) ovf_seen++;
            if (gnt[r]) begin
                lat = i;
                break;
            end
        end
        req = 2'b00;
        @(negedge clk);
        chk("gnt_one_cycle", 32'(gnt), 0);
    endtask

    task automatic scan_at(input int h, input int v, input int exp_digit, input int exp_in);
        display_on = 1'b1;
        hpos = 9'(h);
        vpos = 9'(v);
        @(negedge clk);
        chk("scan_digit",    32'(digit),    exp_digit);
        chk("scan_in_field", 32'(in_field), exp_in);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ov, who;
        reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b1;
        req = '0; cmd_inc = '0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_digit",    32'(digit),    15);
        chk("rst_in_field", 32'(in_field), 0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_gnt",      32'(gnt),      0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_xofs",     32'(xofs),     0);
        reset = 1'b0;

        // scan sweep over and around the field
        for (int v = 0; v < 18; v++) begin
            for (int h = 0; h < 71; h++) begin
                hpos = 9'(h);
                vpos = 9'(v);
                @(negedge clk);
            end
        end
        scan_at(50, 0, 0, 1);
        scan_at(64, 0, 15, 0);
        scan_at(10, 16, 15, 0);
        hpos = 9'd13; vpos = 9'd7;
        @(negedge clk);
        chk("xofs_13", 32'(xofs), 6);
        chk("yofs_7",  32'(yofs), 3);

        // single write
        do_op(0, 1'b0, 2, 7, lat, ov);
        chk("write_latency", lat, 2);
        scan_at(16, 0, 7, 1);

        // 0999 + 1 -> 1000
        do_op(0, 1'b0, 0, 9, lat, ov);
        do_op(0, 1'b0, 1, 9, lat, ov);
        do_op(0, 1'b0, 2, 9, lat, ov);
        do_op(0, 1'b0, 3, 0, lat, ov);
        do_op(0, 1'b1, 0, 0, lat, ov);
        chk("inc999_latency",  lat, 5);
        chk("inc999_overflow", ov, 0);
        scan_at(0,  0, 1, 1);
        scan_at(16, 0, 0, 1);
        scan_at(32, 0, 0, 1);
        scan_at(48, 0, 0, 1);

        // 9999 + 1 -> 0000 with one overflow pulse
        for (int i = 0; i < ND; i++) do_op(1, 1'b0, i, 9, lat, ov);
        do_op(1, 1'b1, 0, 0, lat, ov);
        chk("inc9999_latency",  lat, 5);
        chk("inc9999_overflow", ov, 1);
        scan_at(50, 0, 0, 1);

        // out-of-range address: straight to grant
        do_op(0, 1'b0, 5, 3, lat, ov);
        chk("badaddr_latency", lat, 1);

        // round-robin fairness from reset with both requesters held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        display_on = 1'b0; cmd_inc = 2'b11; wr_addr = '0; req = 2'b11;
        for (int g = 0; g < 6; g++) begin
            who = 9;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (gnt != 2'b00) begin
                    who = (gnt == 2'b01) ? 0 : ((gnt == 2'b10) ? 1 : 8);
                    break;
                end
            end
            chk("rr_order", who, g % 2);
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
        scan_at(50, 0, 6, 1);

        // requests are held off while video is active
        display_on = 1'b1; cmd_inc = 2'b00;
        wr_addr = {3'd1, 3'd0}; wr_data = {4'd5, 4'd0}; req = 2'b10;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("gated_busy", 32'(busy), 0);
        end
        display_on = 1'b0;
        @(negedge clk);
        chk("ungated_busy", 32'(busy), 1);
        who = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt[1]) begin
                who = 1;
                break;
            end
        end
        chk("ungated_gnt", who, 1);
        req = 2'b00;
        @(negedge clk);
        scan_at(32, 0, 5, 1);

        // reset in the middle of a 9999 increment
        for (int i = 0; i < ND; i++) do_op(0, 1'b0, i, 9, lat, ov);
        display_on = 1'b0; cmd_inc = 2'b01; wr_addr = '0; req = 2'b01;
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 1);
        @(negedge clk);
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        chk("midrst_busy",     32'(busy),     0);
        chk("midrst_gnt",      32'(gnt),      0);
        chk("midrst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_gnt_after", 32'(gnt),      0);
        chk("midrst_ovf_after", 32'(overflow), 0);
        scan_at(50, 0, 0, 1);
        scan_at(0, 0, LEAD_EN ? 15 : 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            display_on = ($urandom_range(0, 1) == 1);
            hpos = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 80));
            vpos = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 20));
            req     = 2'($urandom);
            cmd_inc = 2'($urandom);
            wr_addr = 6'($urandom);
            wr_data = ($urandom_range(0, 2) == 0) ? 8'h99 : 8'($urandom);
            @(negedge clk);
        end
        reset = 1'b0; req = 2'b00; display_on = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
